d2d_wrr_arbiter: RTL and testbench



---
 rtl/d2d_arb_pkg.sv | 19 +
 rtl/d2d_rr_picker.sv | 33 +++
 rtl/d2d_wrr_arbiter.sv | 97 +++++++++
 tb/tb_d2d_wrr_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/d2d_arb_pkg.sv
// Shared types and helpers for the D2D weighted round-robin arbiter.
// Holds the lock-state encoding, weight normalisation and modulo increment.
package d2d_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A programmed weight of zero still grants one packet per turn
    function automatic int eff_weight(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/d2d_rr_picker.sv
// Circular first-one picker: lowest set request at or after start, wrapping.
// Purely combinational; works for any channel count, not just powers of 2.
module d2d_rr_picker #(
    parameter int CHANNELS = 2,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [IDX_W-1:0]    start,
    output logic [IDX_W-1:0]    index,
    output logic                valid
);

    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    logic [IDX_W:0]        sum;
    int                    off;

    always_comb begin
        dbl   = {request, request} >> start;
        rot   = dbl[CHANNELS-1:0];
        off   = 0;
        valid = |request;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = {1'b0, start} + (IDX_W + 1)'(off);
        if (sum >= (IDX_W + 1)'(CHANNELS)) begin
            sum = sum - (IDX_W + 1)'(CHANNELS);
        end
        index = valid ? sum[IDX_W-1:0] : '0;
    end

endmodule

// File: rtl/d2d_wrr_arbiter.sv
// Packet-aware weighted round-robin N:1 arbiter for D2D channel muxing.
// Combinational grant; wormhole lock, turn pointer and quota are registered.
module d2d_wrr_arbiter
    import d2d_arb_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [CHANNELS-1:0]                request,
    input  logic                               forwarding_head,
    input  logic                               forwarding_tail,
    input  logic [CHANNELS-1:0][WEIGHT_W-1:0]  weight,
    input  logic                               grant_valid_other_arbiter,
    output logic [IDX_W-1:0]                   grant_index,
    output logic                               grant_valid,
    output logic                               locked
);

    arb_state_t          st;
    logic [IDX_W-1:0]    rr_ptr;
    logic [WEIGHT_W-1:0] used;
    logic [IDX_W-1:0]    lock_idx;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                xfer;
    logic                pkt_end;
    logic [WEIGHT_W-1:0] wsel;
    logic [WEIGHT_W:0]   u;
    logic [WEIGHT_W:0]   w;
    logic                turn_done;
    logic [IDX_W-1:0]    ptr_next;

    d2d_rr_picker #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .request (request),
        .start   (rr_ptr),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

    assign locked      = (st == LOCKED);
    assign grant_index = locked ? lock_idx : pick_idx;
    assign grant_valid = locked ? request[lock_idx] : pick_valid;
    assign xfer        = grant_valid & grant_valid_other_arbiter;
    assign pkt_end     = xfer & forwarding_tail;

    // Quota only accumulates while the pointer's own channel keeps winning
    always_comb begin
        wsel      = weight[grant_index];
        u         = ((grant_index == rr_ptr) ? {1'b0, used} : '0)
                    + (WEIGHT_W + 1)'(1);
        w         = (WEIGHT_W + 1)'(eff_weight(int'(wsel)));
        turn_done = (u >= w);
        ptr_next  = IDX_W'(next_idx(int'(grant_index), CHANNELS));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= IDLE;
            rr_ptr   <= '0;
            used     <= '0;
            lock_idx <= '0;
        end else if (xfer) begin
            if (!locked && forwarding_head && !forwarding_tail) begin
                st       <= LOCKED;
                lock_idx <= grant_index;
            end else if (locked && forwarding_tail) begin
                st <= IDLE;
            end
            if (pkt_end) begin
                if (turn_done) begin
                    rr_ptr <= ptr_next;
                    used   <= '0;
                end else begin
                    rr_ptr <= grant_index;
                    used   <= u[WEIGHT_W-1:0];
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_idx_range: assert property (@(posedge clk) disable iff (!rstn)
        grant_valid |-> (int'(grant_index) < CHANNELS));
    a_no_head_locked: assert property (@(posedge clk) disable iff (!rstn)
        (locked && xfer) |-> !forwarding_head);
    a_lock_stable: assert property (@(posedge clk) disable iff (!rstn)
        locked |=> (!locked || $stable(grant_index)));
`endif

endmodule

// File: tb/tb_d2d_wrr_arbiter.sv
// Scoreboard bench for d2d_wrr_arbiter: a 4-channel and a 3-channel instance.
// Stimulus pushes hand-computed grants; a negedge monitor pops and compares.
module tb_d2d_wrr_arbiter;

    typedef struct {
        string      tag;
        logic [1:0] idx;
        logic       v;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic [3:0]      req4 = '0;
    logic            head4 = 1'b0;
    logic            tail4 = 1'b0;
    logic            peer4 = 1'b0;
    logic [3:0][3:0] w4 = '0;
    logic [1:0]      gi4;
    logic            gv4;
    logic            lk4;

    logic [2:0]      req3 = '0;
    logic            head3 = 1'b0;
    logic            tail3 = 1'b0;
    logic            peer3 = 1'b0;
    logic [2:0][3:0] w3 = '0;
    logic [1:0]      gi3;
    logic            gv3;
    logic            lk3;

    exp_t q4[$];
    exp_t q3[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    d2d_wrr_arbiter #(.CHANNELS(4), .WEIGHT_W(4)) dut4 (
        .clk                       (clk),
        .rstn                      (rstn),
        .request                   (req4),
        .forwarding_head           (head4),
        .forwarding_tail           (tail4),
        .weight                    (w4),
        .grant_valid_other_arbiter (peer4),
        .grant_index               (gi4),
        .grant_valid               (gv4),
        .locked                    (lk4)
    );

    d2d_wrr_arbiter #(.CHANNELS(3), .WEIGHT_W(4)) dut3 (
        .clk                       (clk),
        .rstn                      (rstn),
        .request                   (req3),
        .forwarding_head           (head3),
        .forwarding_tail           (tail3),
        .weight                    (w3),
        .grant_valid_other_arbiter (peer3),
        .grant_index               (gi3),
        .grant_valid               (gv3),
        .locked                    (lk3)
    );

    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            vectors++;
            if (gi4 !== e.idx || gv4 !== e.v || lk4 !== e.l) begin
                miscompares++;
                $display("FAIL %s: got idx=%0d valid=%0b locked=%0b, want idx=%0d valid=%0b locked=%0b",
                         e.tag, gi4, gv4, lk4, e.idx, e.v, e.l);
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            vectors++;
            if (gi3 !== e.idx || gv3 !== e.v || lk3 !== e.l) begin
                miscompares++;
                $display("FAIL %s: got idx=%0d valid=%0b locked=%0b, want idx=%0d valid=%0b locked=%0b",
                         e.tag, gi3, gv3, lk3, e.idx, e.v, e.l);
            end
        end
    end

    task automatic push4(input string tag, input logic [1:0] i,
                         input logic v, input logic l);
        exp_t e;
        e.tag = tag; e.idx = i; e.v = v; e.l = l;
        q4.push_back(e);
    endtask

    task automatic push3(input string tag, input logic [1:0] i,
                         input logic v, input logic l);
        exp_t e;
        e.tag = tag; e.idx = i; e.v = v; e.l = l;
        q3.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        req4 = '0; head4 = 0; tail4 = 0; peer4 = 0;
        req3 = '0; head3 = 0; tail3 = 0; peer3 = 0;
        push4("reset4", 2'd0, 1'b0, 1'b0);
        push3("reset3", 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic step4(input string tag, input logic [3:0] r,
                         input logic h, input logic t, input logic p,
                         input logic [1:0] ei, input logic ev,
                         input logic el);
        @(posedge clk);
        #1;
        req4 = r; head4 = h; tail4 = t; peer4 = p;
        push4(tag, ei, ev, el);
    endtask

    task automatic step3(input string tag, input logic [2:0] r,
                         input logic [1:0] ei, input logic ev);
        @(posedge clk);
        #1;
        req3 = r; head3 = 1'b1; tail3 = 1'b1; peer3 = 1'b1;
        push3(tag, ei, ev, 1'b0);
    endtask

    initial begin
        // Round robin with unit weights: 0,1,2,3 then wrap
        w4 = {4'd1, 4'd1, 4'd1, 4'd1};
        do_reset();
        step4("rr_g0", 4'b1111, 1, 1, 1, 2'd0, 1, 0);
        step4("rr_g1", 4'b1111, 1, 1, 1, 2'd1, 1, 0);
        step4("rr_g2", 4'b1111, 1, 1, 1, 2'd2, 1, 0);
        step4("rr_g3", 4'b1111, 1, 1, 1, 2'd3, 1, 0);
        step4("rr_wrap", 4'b1111, 1, 1, 1, 2'd0, 1, 0);

        // Weighted: channel 0 gets three packets per turn
        w4 = {4'd1, 4'd1, 4'd1, 4'd3};
        do_reset();
        step4("wrr_0a", 4'b0011, 1, 1, 1, 2'd0, 1, 0);
        step4("wrr_0b", 4'b0011, 1, 1, 1, 2'd0, 1, 0);
        step4("wrr_0c", 4'b0011, 1, 1, 1, 2'd0, 1, 0);
        step4("wrr_1", 4'b0011, 1, 1, 1, 2'd1, 1, 0);
        step4("wrr_0d", 4'b0011, 1, 1, 1, 2'd0, 1, 0);
        step4("wrr_0e", 4'b0011, 1, 1, 1, 2'd0, 1, 0);
        step4("wrr_0f", 4'b0011, 1, 1, 1, 2'd0, 1, 0);
        step4("wrr_1b", 4'b0011, 1, 1, 1, 2'd1, 1, 0);

        // Three-flit packet on channel 2 with peer stalls and a dropped request
        w4 = {4'd1, 4'd1, 4'd1, 4'd1};
        do_reset();
        step4("pre_0", 4'b1111, 1, 1, 1, 2'd0, 1, 0);
        step4("pre_1", 4'b1111, 1, 1, 1, 2'd1, 1, 0);
        step4("head_2", 4'b1111, 1, 0, 1, 2'd2, 1, 0);
        step4("body_2", 4'b1111, 0, 0, 1, 2'd2, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step4("stall_2", 4'b1111, 0, 1, 0, 2'd2, 1, 1);
        end
        step4("drop_2", 4'b1011, 0, 1, 1, 2'd2, 0, 1);
        step4("tail_2", 4'b1111, 0, 1, 1, 2'd2, 1, 1);
        step4("after_3", 4'b1111, 1, 1, 1, 2'd3, 1, 0);
        step4("after_0", 4'b1111, 1, 1, 1, 2'd0, 1, 0);

        // Asynchronous reset in the middle of a locked packet
        do_reset();
        step4("ar_0", 4'b1111, 1, 1, 1, 2'd0, 1, 0);
        step4("ar_1", 4'b1111, 1, 1, 1, 2'd1, 1, 0);
        step4("ar_head2", 4'b1111, 1, 0, 1, 2'd2, 1, 0);
        @(posedge clk);
        #1;
        req4 = 4'b1111; head4 = 0; tail4 = 0; peer4 = 1;
        #2;
        rstn = 1'b0;
        push4("async_rst", 2'd0, 1'b1, 1'b0);
        #4;
        rstn = 1'b1;
        step4("post_rst", 4'b1111, 1, 1, 1, 2'd0, 1, 0);
        step4("post_rst1", 4'b1111, 1, 1, 1, 2'd1, 1, 0);

        // Three channels: zero weight on channel 1, then non-power-of-2 wrap
        w3 = {4'd1, 4'd0, 4'd1};
        do_reset();
        step3("w0_a", 3'b010, 2'd1, 1);
        step3("w0_b", 3'b010, 2'd1, 1);
        step3("w0_ptr2", 3'b011, 2'd0, 1);
        step3("c3_1", 3'b111, 2'd1, 1);
        step3("c3_2", 3'b111, 2'd2, 1);
        step3("c3_wrap", 3'b111, 2'd0, 1);
        step3("c3_idle", 3'b000, 2'd0, 0);

        @(posedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
